// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns, blank pattern and scan FSM states for seven_seg_scan.
package seven_seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  // Active-high {a,b,c,d,e,f,g} for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  typedef enum logic {GUARD, SHOW} state_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7 (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  import seven_seg_pkg::*;
  assign o_seg = SEG_LUT[i_hex];
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment driver with frame-aligned updates and guard time.
// Define SEVEN_SEG_LZ_BLANK_EN to enable leading-zero suppression.
module seven_seg_scan #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 100000,
  parameter int GUARD_CYCLES     = 2,
  parameter int SEG_ACTIVE_LOW   = 0,
  parameter int DIGIT_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_done
);
  import seven_seg_pkg::*;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic DP_POL = SEG_ACTIVE_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};
  localparam state_t RST_STATE = GUARD_CYCLES > 0 ? GUARD : SHOW;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, r_pend_blank, r_act_blank, r_lz;
  logic [6:0]              r_seg;
  logic                    r_dp, r_fd;
  logic [NUM_DIGITS-1:0]   r_digit;
  logic                    w_slot_end, w_wrap, w_show, w_blank, w_run;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           w_idx_nxt;
  state_t                  w_state_nxt;
  logic [4*NUM_DIGITS-1:0] w_val_nxt;
  logic [NUM_DIGITS-1:0]   w_dp_nxt, w_blank_nxt, w_lz, w_onehot;
  logic [3:0]              w_nib;
  logic [6:0]              w_hex_seg, w_seg_nxt;
  logic                    w_dp_out_nxt;
  logic [NUM_DIGITS-1:0]   w_digit_nxt;
  hex_to_seg7 u_dec (.i_hex(w_nib), .o_seg(w_hex_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= RST_STATE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end
  always_comb begin
    w_slot_end   = r_cnt == CW'(SCAN_DIV - 1);
    w_wrap       = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));
    w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CW'(1);
    w_idx_nxt    = !w_slot_end ? r_idx : (w_wrap ? '0 : r_idx + IW'(1));
    w_state_nxt  = (w_cnt_nxt < CW'(GUARD_CYCLES)) ? GUARD : SHOW;
    w_show       = r_state == SHOW;
    w_nib        = r_act_val[{r_idx, 2'b00} +: 4];
    w_blank      = r_act_blank[r_idx] | r_lz[r_idx];
    w_onehot     = NUM_DIGITS'(1) << r_idx;
    w_seg_nxt    = (w_show && !w_blank) ? w_hex_seg : SEG_OFF;
    w_dp_out_nxt = w_show && !w_blank && r_act_dp[r_idx];
    w_digit_nxt  = w_show ? w_onehot : '0;
    // A load on the wrap cycle bypasses pending so it lands in the very next frame
    w_val_nxt    = load ? value : r_pend_val;
    w_dp_nxt     = load ? dp_in : r_pend_dp;
    w_blank_nxt  = load ? blank_in : r_pend_blank;
  end
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_run   = w_run && (w_val_nxt[4*i +: 4] == 4'h0) && !w_dp_nxt[i];
      w_lz[i] = w_run;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_lz         <= '0;
      r_seg        <= SEG_OFF ^ SEG_POL;
      r_dp         <= DP_POL;
      r_digit      <= DIG_POL;
      r_fd         <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val   <= value;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
      end
      if (w_wrap) begin
        r_act_val   <= w_val_nxt;
        r_act_dp    <= w_dp_nxt;
        r_act_blank <= w_blank_nxt;
        r_lz        <= w_lz;
      end
      r_seg   <= w_seg_nxt ^ SEG_POL;
      r_dp    <= w_dp_out_nxt ^ DP_POL;
      r_digit <= w_digit_nxt ^ DIG_POL;
      r_fd    <= w_wrap;
    end
  end
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit      = r_digit;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan, active-high and active-low builds in parallel.
module tb_seven_seg_scan;
  localparam int N  = 4;
  localparam int SD = 8;
  localparam int GC = 2;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic [6:0] seg, seg_n;
  logic dp, dp_n, fd, fd_n;
  logic [3:0] digit, digit_n;
  logic [12:0] q_exp[$];
  int errors = 0, checks = 0, m_t = 0;
  logic [15:0] p_val = '0, a_val = '0;
  logic [3:0] p_dp = '0, a_dp = '0, p_bl = '0, a_bl = '0, a_lz = '0;
  always #5 clk = ~clk;
  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(GC)) u_hi (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in), .load(load),
    .seg(seg), .dp(dp), .digit(digit), .frame_done(fd));
  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(GC),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)) u_lo (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in), .load(load),
    .seg(seg_n), .dp(dp_n), .digit(digit_n), .frame_done(fd_n));
  function automatic logic [3:0] lz_of(input logic [15:0] v, input logic [3:0] d);
    logic [3:0] m;
    logic run;
    m = '0;
    run = 1'b1;
    for (int i = 3; i > 0; i--) begin
      run = run && (v[4*i +: 4] == 4'h0) && !d[i];
      m[i] = run && LZ;
    end
    return m;
  endfunction
  task automatic tick();
    logic [12:0] e;
    logic [12:0] got;
    int c, d;
    logic lit, bl;
    e = '0;
    c = m_t % SD;
    d = (m_t / SD) % N;
    if (rst) begin
      m_t = 0;
      p_val = '0; p_dp = '0; p_bl = '0;
      a_val = '0; a_dp = '0; a_bl = '0; a_lz = '0;
    end else begin
      lit = c >= GC;
      bl = a_bl[d] | a_lz[d];
      e[12:6] = (lit && !bl) ? SEG[a_val[4*d +: 4]] : 7'b0;
      e[5] = lit && !bl && a_dp[d];
      e[4:1] = lit ? 4'(1 << d) : 4'b0;
      e[0] = (m_t % (SD * N)) == (SD * N - 1);
      if (load) begin
        p_val = value; p_dp = dp_in; p_bl = blank_in;
      end
      if (e[0]) begin
        a_val = p_val; a_dp = p_dp; a_bl = p_bl;
        a_lz = lz_of(p_val, p_dp);
      end
      m_t++;
    end
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    got = {seg, dp, digit, fd};
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL hi t=%0d got=%b exp=%b", m_t, got, e);
    end
    got = {seg_n, dp_n, digit_n, fd_n};
    checks++;
    assert (got === {~e[12:1], e[0]}) else begin
      errors++;
      $error("FAIL lo t=%0d got=%b exp=%b", m_t, got, {~e[12:1], e[0]});
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic to_wrap();
    while (m_t % (SD * N) != SD * N - 1) tick();
  endtask
  initial begin
    run(3);
    rst = 1'b0;
    do_load(16'h12AF, 4'b0000, 4'b0000);
    run(70);
    do_load(16'h3333, 4'b0000, 4'b0000);
    to_wrap();
    run(12);
    do_load(16'h4444, 4'b0000, 4'b0000);
    run(60);
    to_wrap();
    do_load(16'h0007, 4'b0000, 4'b0000);
    run(34);
    do_load(16'h5678, 4'b0001, 4'b0100);
    run(66);
    do_load(16'h0123, 4'b1010, 4'b0000);
    run(40);
    do_load(16'h4567, 4'b0101, 4'b0000);
    run(40);
    do_load(16'h89AB, 4'b0000, 4'b1001);
    run(40);
    do_load(16'hCDEF, 4'b1111, 4'b0000);
    run(40);
    do_load(16'h8888, 4'b0000, 4'b0000);
    run(45);
    do_load(16'h9E21, 4'b0000, 4'b0000);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(40);
    do_load(16'h0050, 4'b0000, 4'b0000);
    run(66);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(66);
    do_load(16'h0300, 4'b0100, 4'b0000);
    run(66);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
